// File: rtl/bomb_controller.sv
// bomb_controller: one-bomb drop/fuse/blast/cooldown sequencer feeding the VGA pixel compositor.
// Optional macro BOMB_REMOTE_DET_EN: a drop_req edge while armed detonates the bomb at once.
module bomb_controller #(
    parameter int FUSE_TICKS = 12,
    parameter int RAD_MIN    = 8,
    parameter int RAD_STEP   = 8,
    parameter int RAD_MAX    = 48,
    parameter int ARM_HALF_W = 10,
    parameter int COOL_TICKS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       drop_req,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic [9:0] bomb_x,
    output logic [9:0] bomb_y,
    output logic       bomb_active,
    output logic       blast_active,
    output logic [5:0] blast_radius,
    output logic [5:0] fuse_count,
    output logic [3:0] bomb_total,
    output logic       hit_player
);

    // state    | meaning
    // IDLE     | no bomb on screen, drop_req edge accepted
    // ARMED    | bomb placed, fuse counts down on tick
    // BLAST    | cross grows from RAD_MIN to RAD_MAX, hit test live
    // COOLDOWN | waiting out COOL_TICKS before the next drop
    typedef enum logic [1:0] {IDLE, ARMED, BLAST, COOLDOWN} state_t;

    localparam logic [5:0]  FUSE_INIT  = 6'(FUSE_TICKS);
    localparam logic [5:0]  RAD_MIN_V  = 6'(RAD_MIN);
    localparam logic [5:0]  RAD_MAX_V  = 6'(RAD_MAX);
    localparam logic [6:0]  RAD_STEP_V = 7'(RAD_STEP);
    localparam logic [5:0]  COOL_INIT  = 6'(COOL_TICKS);
    localparam logic [10:0] ARM_W      = 11'(ARM_HALF_W);

    state_t      state_q, state_d;
    logic        drop_req_q;
    logic [9:0]  bomb_x_q, bomb_x_d;
    logic [9:0]  bomb_y_q, bomb_y_d;
    logic [5:0]  fuse_q, fuse_d;
    logic [5:0]  rad_q, rad_d;
    logic [5:0]  cool_q, cool_d;
    logic [3:0]  total_q, total_d;
    logic        hit_q, hit_d;
    logic        bomb_active_q, bomb_active_d;
    logic        blast_active_q, blast_active_d;

    logic               drop_edge;
    logic               hit_now;
    logic signed [10:0] dx_s, dy_s;
    logic [10:0]        dx, dy, rad_w;
    logic [6:0]         rad_sum;
    logic [5:0]         rad_grow;

    assign drop_edge = drop_req & ~drop_req_q;

    // Distances are taken against the latched bomb centre, so they may exceed the screen.
    assign dx_s  = $signed({1'b0, player_x}) - $signed({1'b0, bomb_x_q});
    assign dy_s  = $signed({1'b0, player_y}) - $signed({1'b0, bomb_y_q});
    assign dx    = dx_s[10] ? $unsigned(-dx_s) : $unsigned(dx_s);
    assign dy    = dy_s[10] ? $unsigned(-dy_s) : $unsigned(dy_s);
    assign rad_w = {5'b0, rad_q};

    assign hit_now = ((dx <= rad_w) && (dy <= ARM_W)) || ((dy <= rad_w) && (dx <= ARM_W));

    assign rad_sum  = {1'b0, rad_q} + RAD_STEP_V;
    assign rad_grow = (rad_sum > {1'b0, RAD_MAX_V}) ? RAD_MAX_V : rad_sum[5:0];

    always_comb begin
        state_d  = state_q;
        bomb_x_d = bomb_x_q;
        bomb_y_d = bomb_y_q;
        fuse_d   = fuse_q;
        rad_d    = rad_q;
        cool_d   = cool_q;
        total_d  = total_q;
        hit_d    = hit_q;

        case (state_q)
            IDLE: begin
                if (drop_edge) begin
                    bomb_x_d = player_x;
                    bomb_y_d = player_y;
                    fuse_d   = FUSE_INIT;
                    total_d  = (total_q == 4'd15) ? total_q : total_q + 4'd1;
                    hit_d    = 1'b0;
                    state_d  = ARMED;
                end
            end
            ARMED: begin
`ifdef BOMB_REMOTE_DET_EN
                if (drop_edge) begin
                    fuse_d  = 6'd0;
                    rad_d   = RAD_MIN_V;
                    state_d = BLAST;
                end else
`endif
                if (tick) begin
                    if (fuse_q > 6'd1) begin
                        fuse_d = fuse_q - 6'd1;
                    end else begin
                        fuse_d  = 6'd0;
                        rad_d   = RAD_MIN_V;
                        state_d = BLAST;
                    end
                end
            end
            BLAST: begin
                if (hit_now) begin
                    hit_d = 1'b1;
                end
                if (tick) begin
                    if (rad_q < RAD_MAX_V) begin
                        rad_d = rad_grow;
                    end else begin
                        rad_d   = 6'd0;
                        cool_d  = COOL_INIT;
                        state_d = COOLDOWN;
                    end
                end
            end
            COOLDOWN: begin
                // A zero count leaves on the first tick, same as a count of one.
                if (tick) begin
                    if (cool_q <= 6'd1) begin
                        cool_d  = 6'd0;
                        state_d = IDLE;
                    end else begin
                        cool_d = cool_q - 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        bomb_active_d  = (state_d == ARMED);
        blast_active_d = (state_d == BLAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            drop_req_q     <= 1'b0;
            bomb_x_q       <= 10'd0;
            bomb_y_q       <= 10'd0;
            fuse_q         <= 6'd0;
            rad_q          <= 6'd0;
            cool_q         <= 6'd0;
            total_q        <= 4'd0;
            hit_q          <= 1'b0;
            bomb_active_q  <= 1'b0;
            blast_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            drop_req_q     <= drop_req;
            bomb_x_q       <= bomb_x_d;
            bomb_y_q       <= bomb_y_d;
            fuse_q         <= fuse_d;
            rad_q          <= rad_d;
            cool_q         <= cool_d;
            total_q        <= total_d;
            hit_q          <= hit_d;
            bomb_active_q  <= bomb_active_d;
            blast_active_q <= blast_active_d;
        end
    end

    assign bomb_x       = bomb_x_q;
    assign bomb_y       = bomb_y_q;
    assign bomb_active  = bomb_active_q;
    assign blast_active = blast_active_q;
    assign blast_radius = rad_q;
    assign fuse_count   = fuse_q;
    assign bomb_total   = total_q;
    assign hit_player   = hit_q;

endmodule

// File: tb/tb_bomb_controller.sv
// tb_bomb_controller: directed vector table, hand-written corner sequences and a
// randomized run against a tick-count reference model of the bomb lifecycle.
module tb_bomb_controller;

    localparam int F     = 12;
    localparam int RMIN  = 8;
    localparam int RSTEP = 8;
    localparam int RMAX  = 48;
    localparam int AHW   = 10;
    localparam int COOL  = 4;
`ifdef BOMB_REMOTE_DET_EN
    localparam bit REMOTE = 1'b1;
`else
    localparam bit REMOTE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       drop_req;
    logic [9:0] player_x;
    logic [9:0] player_y;
    logic [9:0] bomb_x;
    logic [9:0] bomb_y;
    logic       bomb_active;
    logic       blast_active;
    logic [5:0] blast_radius;
    logic [5:0] fuse_count;
    logic [3:0] bomb_total;
    logic       hit_player;

    int checks   = 0;
    int failures = 0;

    always #20 clk = ~clk;

    bomb_controller #(
        .FUSE_TICKS(F), .RAD_MIN(RMIN), .RAD_STEP(RSTEP),
        .RAD_MAX(RMAX), .ARM_HALF_W(AHW), .COOL_TICKS(COOL)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .drop_req(drop_req),
        .player_x(player_x), .player_y(player_y),
        .bomb_x(bomb_x), .bomb_y(bomb_y),
        .bomb_active(bomb_active), .blast_active(blast_active),
        .blast_radius(blast_radius), .fuse_count(fuse_count),
        .bomb_total(bomb_total), .hit_player(hit_player)
    );

    typedef logic [38:0] obs_t;
    obs_t dut_obs;
    assign dut_obs = {bomb_x, bomb_y, bomb_active, blast_active, blast_radius,
                      fuse_count, bomb_total, hit_player};

    function automatic obs_t mk(input int bx, input int by, input bit ea, input bit eb,
                                input int r, input int f, input int t, input bit h);
        return {10'(bx), 10'(by), ea, eb, 6'(r), 6'(f), 4'(t), h};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("bomb=(%0d,%0d) act=%0b blast=%0b rad=%0d fuse=%0d total=%0d hit=%0b",
                         o[38:29], o[28:19], o[18], o[17], o[16:11], o[10:5], o[4:1], o[0]);
    endfunction

    task automatic chk(input string name, input obs_t exp);
        checks++;
        if (dut_obs !== exp) begin
            failures++;
            $display("FAIL %s: got %s, required %s", name, fmt(dut_obs), fmt(exp));
        end
    endtask

    // Reference model: a bomb is described only by how many ticks have elapsed since its drop.
    bit m_act, m_prev, m_hit;
    int m_k, m_total, m_bx, m_by;
    int nb, cool_len;

    function automatic int m_phase();
        if (!m_act) return 0;
        if (m_k < F) return 1;
        if (m_k < F + nb) return 2;
        return 3;
    endfunction

    function automatic int m_rad();
        int r;
        if (m_phase() != 2) return 0;
        r = RMIN + (m_k - F) * RSTEP;
        return (r > RMAX) ? RMAX : r;
    endfunction

    function automatic obs_t m_obs();
        return mk(m_bx, m_by, m_phase() == 1, m_phase() == 2, m_rad(),
                  (m_phase() == 1) ? F - m_k : 0, m_total, m_hit);
    endfunction

    task automatic m_reset();
        m_act = 0; m_prev = 0; m_hit = 0; m_k = 0; m_total = 0; m_bx = 0; m_by = 0;
    endtask

    task automatic m_update(input bit t, input bit d, input int px, input int py);
        bit e;
        int dx, dy, r;
        e = d && !m_prev;
        m_prev = d;
        if (m_phase() == 2) begin
            dx = (px > m_bx) ? px - m_bx : m_bx - px;
            dy = (py > m_by) ? py - m_by : m_by - py;
            r  = m_rad();
            if ((dx <= r && dy <= AHW) || (dy <= r && dx <= AHW)) m_hit = 1;
        end
        if (!m_act) begin
            if (e) begin
                m_act = 1; m_k = 0; m_bx = px; m_by = py; m_hit = 0;
                m_total = (m_total < 15) ? m_total + 1 : 15;
            end
        end else if (REMOTE && m_phase() == 1 && e) begin
            m_k = F;
        end else if (t) begin
            m_k++;
            if (m_k >= F + nb + cool_len) m_act = 0;
        end
    endtask

    task automatic step(input bit use_model);
        @(posedge clk);
        if (use_model) m_update(tick, drop_req, int'(player_x), int'(player_y));
        #1;
    endtask

    task automatic pulse_drop();
        drop_req = 1'b1; step(0);
        drop_req = 1'b0; step(0);
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; step(0);
            tick = 1'b0; step(0);
        end
    endtask

    typedef struct {
        string name;
        bit    drop;
        int    nt;
        int    px, py;
        bit    ea, eb;
        int    er, ef, et;
        bit    eh;
        int    ebx, eby;
    } vec_t;

    vec_t vt[12];

    initial begin
        nb = 1;
        while (RMIN + (nb - 1) * RSTEP < RMAX) nb++;
        cool_len = (COOL == 0) ? 1 : COOL;

        vt[0]  = '{"drop_armed",         1'b1, 0,  100, 240, 1'b1, 1'b0, 0,  12, 1, 1'b0, 100, 240};
        vt[1]  = '{"fuse_at_1",          1'b0, 11, 130, 244, 1'b1, 1'b0, 0,  1,  1, 1'b0, 100, 240};
        vt[2]  = '{"blast_r8",           1'b0, 1,  130, 244, 1'b0, 1'b1, 8,  0,  1, 1'b0, 100, 240};
        vt[3]  = '{"r24_miss",           1'b0, 2,  130, 244, 1'b0, 1'b1, 24, 0,  1, 1'b0, 100, 240};
        vt[4]  = '{"r32_hit",            1'b0, 1,  130, 244, 1'b0, 1'b1, 32, 0,  1, 1'b1, 100, 240};
        vt[5]  = '{"r48_cap",            1'b0, 2,  130, 244, 1'b0, 1'b1, 48, 0,  1, 1'b1, 100, 240};
        vt[6]  = '{"cooldown_entry",     1'b0, 1,  130, 244, 1'b0, 1'b0, 0,  0,  1, 1'b1, 100, 240};
        vt[7]  = '{"cooldown_drop_ign",  1'b1, 3,  130, 244, 1'b0, 1'b0, 0,  0,  1, 1'b1, 100, 240};
        vt[8]  = '{"idle_hit_sticky",    1'b0, 1,  130, 244, 1'b0, 1'b0, 0,  0,  1, 1'b1, 100, 240};
        vt[9]  = '{"redrop_clears_hit",  1'b1, 0,  100, 240, 1'b1, 1'b0, 0,  12, 2, 1'b0, 100, 240};
        vt[10] = '{"dy20_miss_r48",      1'b0, 17, 130, 260, 1'b0, 1'b1, 48, 0,  2, 1'b0, 100, 240};
        vt[11] = '{"back_to_idle",       1'b0, 5,  130, 260, 1'b0, 1'b0, 0,  0,  2, 1'b0, 100, 240};

        reset = 1'b1; tick = 1'b0; drop_req = 1'b0; player_x = '0; player_y = '0;
        #5;
        chk("reset_values", mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vt[i]) begin
            player_x = 10'(vt[i].px);
            player_y = 10'(vt[i].py);
            if (vt[i].drop) pulse_drop();
            run_ticks(vt[i].nt);
            chk(vt[i].name, mk(vt[i].ebx, vt[i].eby, vt[i].ea, vt[i].eb,
                               vt[i].er, vt[i].ef, vt[i].et, vt[i].eh));
        end

        // Tick coinciding with the accepted drop must not shorten the new fuse.
        player_x = 10'd200; player_y = 10'd100;
        drop_req = 1'b1; tick = 1'b1; step(0);
        drop_req = 1'b0; tick = 1'b0; step(0);
        chk("drop_with_tick", mk(200, 100, 1, 0, 0, 12, 3, 0));

        pulse_drop();
        if (REMOTE) begin
            chk("armed_drop_remote", mk(200, 100, 0, 1, 8, 0, 3, 0));
            run_ticks(nb + cool_len);
        end else begin
            chk("armed_drop_ignored", mk(200, 100, 1, 0, 0, 12, 3, 0));
            run_ticks(F + nb + cool_len);
        end

        player_x = 10'd300; player_y = 10'd300;
        for (int i = 0; i < 12; i++) begin
            pulse_drop();
            if (i != 11) run_ticks(F + nb + cool_len);
        end
        chk("total_reaches_15", mk(300, 300, 1, 0, 0, 12, 15, 0));
        run_ticks(F + nb + cool_len);
        pulse_drop();
        chk("total_saturates", mk(300, 300, 1, 0, 0, 12, 15, 0));

        run_ticks(F + 1);
        chk("pre_reset_blast", mk(300, 300, 0, 1, 16, 0, 15, 1));
        @(negedge clk);
        #3 reset = 1'b1;
        #1;
        chk("async_reset_blast", mk(0, 0, 0, 0, 0, 0, 0, 0));

        // Randomized run against the reference model.
        m_reset();
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) drop_req = ~drop_req;
            if ($urandom_range(0, 7) == 0) begin
                player_x = 10'($urandom_range(0, 639));
                player_y = 10'($urandom_range(0, 479));
            end else begin
                player_x = 10'($urandom_range(260, 380));
                player_y = 10'($urandom_range(180, 300));
            end
            step(1);
            chk($sformatf("random_c%0d", c), m_obs());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bomb_controller.md
Name: bomb_controller

Overview:
- Game-logic stage between the button/position logic and the VGA pixel compositor.
- Accepts a drop request and the player position, and places one bomb at the position latched on that request.
- Runs fuse, blast and cooldown phases on a slow game tick.
- Outputs registered bomb position, phase flags, blast radius and a player-hit flag; the pixel compositor turns these into colour terms.

Parameters:
- FUSE_TICKS, 12: game ticks from drop to detonation; legal range 1..63.
- RAD_MIN, 8: blast half-length in pixels at detonation.
- RAD_STEP, 8: radius growth per tick during blast.
- RAD_MAX, 48: blast half-length cap; must be at most 63 and at least RAD_MIN.
- ARM_HALF_W, 10: half-width of each cross arm in pixels.
- COOL_TICKS, 4: ticks after blast before a new drop is accepted.

Ports:
- clk, input, 1: system clock (25 MHz pixel-domain clock).
- reset, input, 1: asynchronous, active-high; clears all state.
- tick, input, 1: one-clk-wide game-tick enable.
- drop_req, input, 1: level input from the debounced centre button; rising edge detected internally.
- player_x, input, 10: player centre X, 0..639.
- player_y, input, 10: player centre Y, 0..479.
- bomb_x, output, 10: latched bomb centre X.
- bomb_y, output, 10: latched bomb centre Y.
- bomb_active, output, 1: high in ARMED.
- blast_active, output, 1: high in BLAST.
- blast_radius, output, 6: current arm half-length; 0 outside BLAST.
- fuse_count, output, 6: remaining fuse ticks; 0 outside ARMED.
- bomb_total, output, 4: bombs placed since reset; saturates at 15.
- hit_player, output, 1: sticky hit flag.

Behaviour:
- Reset values: every output is 0, state is IDLE, and the drop_req edge register is 0.
- All outputs are registered.
- Edge detect: drop_edge = drop_req & ~drop_req_q, where drop_req_q is updated every clk.
- IDLE, on drop_edge:
  - bomb_x and bomb_y latch player_x and player_y.
  - fuse_count loads FUSE_TICKS.
  - bomb_total increments, holding at 15.
  - Next state is ARMED; bomb_active rises on the following clk edge.
- ARMED:
  - On tick with fuse_count > 1, fuse_count decrements.
  - On tick with fuse_count == 1: fuse_count goes to 0, blast_radius loads RAD_MIN, state goes to BLAST.
  - drop_edge is ignored.
- BLAST:
  - On tick with blast_radius < RAD_MAX: blast_radius = min(blast_radius + RAD_STEP, RAD_MAX), computed 7-bit then clamped.
  - On tick with blast_radius == RAD_MAX: blast_radius goes to 0, cooldown counter loads COOL_TICKS, state goes to COOLDOWN.
  - With the defaults, the blast lasts 6 ticks (8, 16, 24, 32, 40, 48).
- COOLDOWN:
  - Each tick decrements the counter; on the tick where the counter is 1, state goes to IDLE.
  - drop_edge is ignored.
  - COOL_TICKS = 0 means exit on the first tick.
- Hit test (evaluated in BLAST only):
  - dx = |player_x - bomb_x| and dy = |player_y - bomb_y|, both computed as 11-bit signed then absolute value.
  - hit = (dx <= blast_radius && dy <= ARM_HALF_W) || (dy <= blast_radius && dx <= ARM_HALF_W).
  - hit sets hit_player on the next clk.
  - hit_player stays high until the next IDLE->ARMED transition or reset.
- Simultaneous events: tick and drop_edge in the same IDLE cycle means the drop is taken and the tick has no effect on the new fuse.
- Clipping: bomb coordinates are not clamped; the compositor clips to the screen.
- Reset mid-operation: an asynchronous return to IDLE with all outputs 0, including hit_player and bomb_total.
- A tick arriving without a clk edge cannot occur, because tick is synchronous to clk.

Optional Feature:
- BOMB_REMOTE_DET_EN defined: in ARMED, drop_edge forces immediate detonation. On the next clk, fuse_count = 0, blast_radius = RAD_MIN and state = BLAST, regardless of tick. If tick and drop_edge coincide, the detonation wins.
- BOMB_REMOTE_DET_EN undefined: drop_edge in ARMED is ignored, as described above.

Test Plan:
- Reset, then drop_req rises with player (100,240) -> next clk: bomb (100,240), bomb_active=1, fuse_count=12, bomb_total=1.
- Default parameters, 12 ticks after drop -> blast_active=1, radius=8; after 5 more ticks radius=48; 1 more tick -> COOLDOWN, radius=0; 4 ticks later IDLE.
- Player at (130,244), bomb at (100,240):
  - radius 24 -> hit_player=0.
  - radius 32 -> hit_player=1.
  - hit_player remains 1 through COOLDOWN and IDLE, and clears on the next drop.
- Player at (130,260), bomb at (100,240), radius 48 -> hit_player=0 (dy=20 > ARM_HALF_W).
- drop_req pulses during ARMED and COOLDOWN:
  - Macro off: no change, bomb_total unchanged.
  - Macro on: a pulse in ARMED gives BLAST next clk with radius 8.
- 16 complete drop cycles -> bomb_total saturates at 15.
- Reset asserted mid-BLAST -> all outputs 0 immediately, without a clk edge.
